fetch_ctrl: RTL and testbench

//  Sequencer for the fetch stage. Owns the fetch PC, drives the synchronous instruction memory

---
 rtl/fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_ctrl_adder.sv | 16 +
 rtl/fetch_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: datapath widths, FSM state encoding,
// the default halt encoding and the PC alignment helper.
package fetch_ctrl_pkg;

   localparam int WORD      = 64;
   localparam int INSTR_LEN = 32;

   // HLT #0 stops the fetch stage once decode has taken it
   localparam logic [INSTR_LEN-1:0] HALT_INSTR_DEFAULT = 32'hD440_0000;

   // Sequential fetch stride in bytes
   localparam logic [WORD-1:0] PC_STEP = 64'd4;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_t;

   // Instructions are word aligned, so the low two address bits are dropped
   function automatic logic [WORD-1:0] align_word(input logic [WORD-1:0] addr);
      return {addr[WORD-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_adder.sv
// Plain modulo-2^W adder shared by the fetch stage for the sequential
// (fetch_pc + 4) and redirect (target + 4) next-PC computations.
module fetch_ctrl_adder #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   // Carry out is discarded on purpose: PC arithmetic wraps around
   always_comb begin
      sum = a + b;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage sequencer. Owns the fetch PC, drives the synchronous
// instruction memory address and hands {instr, pc} to decode with a
// valid/ready handshake. Handles decode back-pressure by re-reading the
// pending address, branch redirects with a one-cycle flush, and halt.
//
// Build option: define FETCH_PERF_CNT_EN to add the saturating performance
// counters perf_fetched, perf_stalls and perf_flushes.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [WORD-1:0]      RESET_PC   = '0,
   parameter logic [INSTR_LEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 branch_taken,
   input  logic [WORD-1:0]      branch_target,
   output logic [WORD-1:0]      imem_addr,
   input  logic [INSTR_LEN-1:0] imem_instr,
   output logic                 if_valid,
   input  logic                 id_ready,
   output logic [INSTR_LEN-1:0] if_instr,
   output logic [WORD-1:0]      if_pc,
   output logic                 flush,
   output logic                 halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_stalls,
   output logic [31:0]          perf_flushes
`endif
);

   fetch_state_t state_q, state_d;

   logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
   logic [WORD-1:0] pend_pc_q, pend_pc_d;
   logic            pend_valid_q, pend_valid_d;
   logic            flush_q, flush_d;

   logic [WORD-1:0] fetch_pc_plus4;
   logic [WORD-1:0] tgt_aligned;
   logic [WORD-1:0] tgt_plus4;

   logic in_run;
   logic accept;
   logic stall;
   logic halt_hit;

   assign tgt_aligned = align_word(branch_target);

   fetch_ctrl_adder #(.W(WORD)) u_seq_adder (
      .a   (fetch_pc_q),
      .b   (PC_STEP),
      .sum (fetch_pc_plus4)
   );

   fetch_ctrl_adder #(.W(WORD)) u_tgt_adder (
      .a   (tgt_aligned),
      .b   (PC_STEP),
      .sum (tgt_plus4)
   );

   // Handshake qualifiers; accept already excludes a redirect cycle, so a
   // halt word arriving alongside a branch is squashed rather than obeyed
   always_comb begin
      in_run   = (state_q == FETCH_RUN);
      accept   = if_valid & id_ready;
      stall    = if_valid & ~id_ready;
      halt_hit = accept & (imem_instr == HALT_INSTR);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_IDLE: begin
            if (start) begin
               state_d = FETCH_RUN;
            end
         end
         FETCH_RUN: begin
            if (halt_hit) begin
               state_d = FETCH_HALT;
            end
         end
         FETCH_HALT: begin
            state_d = FETCH_HALT;
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   // FSM outputs: handshake, memory address and status towards decode
   always_comb begin
      if_valid  = 1'b0;
      imem_addr = fetch_pc_q;
      halted    = 1'b0;
      if_instr  = imem_instr;
      if_pc     = pend_pc_q;
      flush     = flush_q;
      case (state_q)
         FETCH_IDLE: begin
            imem_addr = RESET_PC;
         end
         FETCH_RUN: begin
            if_valid = pend_valid_q & ~branch_taken;
            if (branch_taken) begin
               imem_addr = tgt_aligned;
            end else if (pend_valid_q & ~id_ready) begin
               imem_addr = pend_pc_q;
            end else begin
               imem_addr = fetch_pc_q;
            end
         end
         FETCH_HALT: begin
            halted = 1'b1;
         end
         default: begin
            imem_addr = fetch_pc_q;
         end
      endcase
   end

   // Next values of the PC pipeline. In IDLE fetch_pc still holds RESET_PC,
   // so the sequential adder already yields RESET_PC + 4 for the first step.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      flush_d      = in_run & branch_taken;
      case (state_q)
         FETCH_IDLE: begin
            if (start) begin
               pend_pc_d    = RESET_PC;
               pend_valid_d = 1'b1;
               fetch_pc_d   = fetch_pc_plus4;
            end
         end
         FETCH_RUN: begin
            if (branch_taken) begin
               pend_pc_d    = tgt_aligned;
               pend_valid_d = 1'b1;
               fetch_pc_d   = tgt_plus4;
            end else if (halt_hit) begin
               pend_valid_d = 1'b0;
            end else if (stall) begin
               pend_pc_d    = pend_pc_q;
            end else begin
               pend_pc_d    = fetch_pc_q;
               pend_valid_d = 1'b1;
               fetch_pc_d   = fetch_pc_plus4;
            end
         end
         default: begin
            fetch_pc_d = fetch_pc_q;
         end
      endcase
   end

   // PC pipeline registers and the registered flush pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         pend_pc_q    <= '0;
         pend_valid_q <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
         flush_q      <= flush_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating event counters: delivered instructions, stall cycles, flushes
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
         perf_flushes <= '0;
      end else begin
         if (accept && (perf_fetched != 32'hFFFF_FFFF)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (stall && (perf_stalls != 32'hFFFF_FFFF)) begin
            perf_stalls <= perf_stalls + 32'd1;
         end
         if (flush_q && (perf_flushes != 32'hFFFF_FFFF)) begin
            perf_flushes <= perf_flushes + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by randomized
// traffic, checked every cycle against a PC-level behavioural model.
module tb_fetch_ctrl;

   localparam logic [63:0] RESET_PC  = 64'h0;
   localparam logic [31:0] HALT_WORD = 32'hD440_0000;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_HALT = 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        flush;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
   logic [31:0] perf_flushes;
`endif

   int checks = 0;
   int errors = 0;

   logic [63:0] halt_addr;

   int          m_state;
   logic [63:0] m_pc;
   bit          m_flush;
   logic [31:0] m_fetched;
   logic [31:0] m_stalls;
   logic [31:0] m_flushes;

   fetch_ctrl #(
      .RESET_PC   (RESET_PC),
      .HALT_INSTR (HALT_WORD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .if_valid      (if_valid),
      .id_ready      (id_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .flush         (flush),
      .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_stalls   (perf_stalls),
      .perf_flushes  (perf_flushes)
`endif
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: the halt word at halt_addr, otherwise an address-derived
   // pattern with bit 0 set so it can never alias the halt encoding
   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      if (addr == halt_addr) begin
         return HALT_WORD;
      end
      return {addr[31:2] ^ addr[61:32], 2'b01};
   endfunction

   // Synchronous instruction memory with one cycle of read latency
   always @(posedge clk) begin
      imem_instr <= mem_word(imem_addr);
   end

   // Single comparison point; every check is counted here
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Drive one cycle of inputs, compare all outputs against the model, then
   // advance the model to the state it expects after the coming clock edge
   task automatic applyStimulus(input bit rst, input bit st, input bit br,
                                input logic [63:0] tgt, input bit rdy);
      bit          exp_valid;
      logic [63:0] exp_addr;
      @(negedge clk);
      reset         = rst;
      start         = st;
      branch_taken  = br;
      branch_target = tgt;
      id_ready      = rdy;
      #1;
      exp_valid = (m_state == S_RUN) && !br;
      if (m_state == S_IDLE) begin
         exp_addr = RESET_PC;
      end else if (m_state == S_HALT) begin
         exp_addr = m_pc + 64'd4;
      end else if (br) begin
         exp_addr = {tgt[63:2], 2'b00};
      end else if (!rdy) begin
         exp_addr = m_pc;
      end else begin
         exp_addr = m_pc + 64'd4;
      end
      checkOutput("if_valid", {63'd0, if_valid}, {63'd0, exp_valid});
      checkOutput("imem_addr", imem_addr, exp_addr);
      checkOutput("halted", {63'd0, halted}, {63'd0, (m_state == S_HALT)});
      checkOutput("flush", {63'd0, flush}, {63'd0, m_flush});
      if (exp_valid) begin
         checkOutput("if_pc", if_pc, m_pc);
         checkOutput("if_instr", {32'd0, if_instr}, {32'd0, mem_word(m_pc)});
      end
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
      checkOutput("perf_stalls", {32'd0, perf_stalls}, {32'd0, m_stalls});
      checkOutput("perf_flushes", {32'd0, perf_flushes}, {32'd0, m_flushes});
`endif
      if (rst) begin
         m_state   = S_IDLE;
         m_flush   = 1'b0;
         m_fetched = '0;
         m_stalls  = '0;
         m_flushes = '0;
      end else begin
         if (m_flush) m_flushes = sat_inc(m_flushes);
         if (exp_valid && rdy) m_fetched = sat_inc(m_fetched);
         if (exp_valid && !rdy) m_stalls = sat_inc(m_stalls);
         m_flush = (m_state == S_RUN) && br;
         if (m_state == S_IDLE) begin
            if (st) begin
               m_state = S_RUN;
               m_pc    = RESET_PC;
            end
         end else if (m_state == S_RUN) begin
            if (br) begin
               m_pc = {tgt[63:2], 2'b00};
            end else if (rdy) begin
               if (mem_word(m_pc) == HALT_WORD) m_state = S_HALT;
               else m_pc = m_pc + 64'd4;
            end
         end
      end
   endtask

   // Run with decode always ready until the model presents the target PC
   task automatic runUntil(input logic [63:0] target, input int max_cycles);
      int n;
      n = 0;
      while ((m_pc != target) && (n < max_cycles)) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
         n++;
      end
      if (m_pc != target) checkOutput("reach_timeout", m_pc, target);
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      id_ready      = 1'b0;
      halt_addr     = 64'h1;
      m_state       = S_IDLE;
      m_pc          = '0;
      m_flush       = 1'b0;
      m_fetched     = '0;
      m_stalls      = '0;
      m_flushes     = '0;
      repeat (2) @(posedge clk);

      // Reset state, then an idle cycle without start
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h40, 1'b1);

      // Start and stream sequentially up to 0x8
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
      runUntil(64'h8, 20);

      // Three stall cycles at 0x8, then resume
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

      // Redirect to 0x100 while 0x10 is pending
      runUntil(64'h10, 20);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h100, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

      // Stall followed by a redirect with an unaligned target while stalled
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h103, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

      // Halt word at 0x20; branches and start are ignored afterwards
      halt_addr = 64'h20;
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h18, 1'b1);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 64'h200, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

      // PC wrap-around at the top of the address space
      halt_addr = 64'h1;
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

      // Randomized traffic including occasional mid-run resets
      for (int i = 0; i < 800; i++) begin
         bit          r_rst;
         bit          r_br;
         logic [63:0] r_tgt;
         r_rst = ($urandom_range(0, 99) < 2);
         r_br  = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 9) == 0) r_tgt = {$urandom, $urandom};
         else r_tgt = {54'd0, 10'($urandom_range(0, 1023))};
         if (r_rst) halt_addr = {54'd0, 8'($urandom_range(0, 255)), 2'b00};
         applyStimulus(r_rst, ($urandom_range(0, 3) == 0), r_br, r_tgt,
                       ($urandom_range(0, 99) < 75));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
